// File: rtl/regfile_wb_arbiter_pkg.sv
// Package regfile_pkg: register-file geometry shared by the register file and
// the writeback arbiter.
//   XLEN     - data width
//   AW       - register address width
//   REG_ZERO - address of x0, which is hard-wired to zero
//   NUM_REGS - number of architectural registers
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // True when a write to this address must not reach the register file.
    function automatic logic is_reg_zero(input logic [AW-1:0] rd);
        return rd == REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle between NUM_REQ writeback sources and the arbiter.
//   req_valid  - requester i has a write pending
//   req_rd     - destination register of requester i, i at [i*AW +: AW]
//   req_data   - write data of requester i, i at [i*XLEN +: XLEN]
//   req_ready  - one-hot grant from the arbiter
// Handshake: a transfer happens on a rising clk edge where req_valid[i] and
// req_ready[i] are both high. The requester holds valid, rd and data stable
// until that edge; ready never rises without the matching valid, and ready
// may depend combinationally on valid. Dropping valid before ready discards
// the request.
// Modports: master = writeback source side, slave = arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*AW-1:0]   req_rd;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: rotating-priority grant over NUM_REQ requests.
//   clk, reset - clock, asynchronous active-high reset (pointer -> 0)
//   req        - request vector (already masked by hold in the caller)
//   grant      - one-hot grant, zero when no request
//   ptr_q      - current highest-priority index, exposed for observation
// The search starts at ptr_q and wraps NUM_REQ-1 -> 0; the first requesting
// index wins. After a grant to g the pointer moves to g+1 (wrapping), so the
// winner becomes lowest priority next cycle. No grant leaves ptr unchanged.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      ptr_q
);

    logic [PW-1:0] ptr_nxt;
    logic          found;
    int            idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            // Compare against a constant index so every select is static.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) ptr_nxt = (i == NUM_REQ - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_nxt;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port among
// NUM_REQ writeback sources with round-robin arbitration.
//   clk, reset     - clock, asynchronous active-high reset
//   hold           - 1 suspends all grants (a write already registered completes)
//   wb             - requester bundle (slave side): valid/rd/data in, ready out
//   rf_we          - registered write enable, low for x0 writes and idle cycles
//   rf_rd          - registered rd_select, holds its value when idle
//   rf_wdata       - registered data_in, holds its value when idle
//   stat_conflicts - saturating count of cycles with hold=0 and >=2 valids
// Optional build macro WB_ARB_STAT_EN enables the conflict counter; without
// it stat_conflicts is tied to zero. Arbitration is the same either way.
// A grant in cycle N appears on rf_* in cycle N+1; the write port never
// stalls, so one write per cycle is sustained.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hold,
    regfile_wb_arbiter_if.slave wb,
    output logic                rf_we,
    output logic [AW-1:0]       rf_rd,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [15:0]         stat_conflicts
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req_masked;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      rr_ptr;
    logic               grant_any;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;

    assign req_masked   = wb.req_valid & {NUM_REQ{~hold}};
    assign wb.req_ready = grant;
    assign grant_any    = |grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req_masked),
        .grant (grant),
        .ptr_q (rr_ptr)
    );

    // One-hot mux of the granted requester's rd and data.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = wb.req_rd[i*AW +: AW];
                sel_data = wb.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes still consume the grant and load rd/data; only the enable
    // is suppressed so the register file never sees them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (grant_any) begin
            rf_we    <= ~is_reg_zero(sel_rd);
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_ARB_STAT_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else if (!hold && ($countones(wb.req_valid) >= 2) && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_conflicts = stat_q;
`else
    assign stat_conflicts = 16'h0;
`endif

endmodule
